// File: rtl/tt_sweep_checker_pkg.sv
// ---------------------------------------------------------------------------
// tt_sweep_pkg : shared types and sizes for the truth-table sweep checker
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package tt_sweep_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;
  localparam int ERR_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Width of a counter spanning 0..cycles-1, never narrower than one bit.
  function automatic int hold_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// tt_sweep_checker_if : stimulus/response and result bundle of the checker
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface tt_sweep_checker_if;
  import tt_sweep_pkg::*;

  logic                   start;
  logic [NUM_VECTORS-1:0] exp_x;
  logic [NUM_VECTORS-1:0] exp_y;
  logic                   X;
  logic                   Y;
  logic                   A;
  logic                   B;
  logic                   C;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [ERR_W-1:0]       err_count;
  logic [VEC_W-1:0]       first_err_idx;
  logic [NUM_VECTORS-1:0] result_x;
  logic [NUM_VECTORS-1:0] result_y;

  // master: the checker itself; slave: the environment and circuit under test
  modport master (
    input  start, exp_x, exp_y, X, Y,
    output A, B, C, busy, done, pass, err_count, first_err_idx, result_x, result_y
  );

  modport slave (
    output start, exp_x, exp_y, X, Y,
    input  A, B, C, busy, done, pass, err_count, first_err_idx, result_x, result_y
  );

endinterface

`default_nettype wire

// File: rtl/tt_sweep_checker_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer : counts 0..HOLD_CYCLES-1 while enabled, flags the last count
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hold_timer
  import tt_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = hold_cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && !load_i && (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/tt_sweep_checker.sv
// ---------------------------------------------------------------------------
// tt_sweep_checker : drives all 8 A/B/C vectors, captures X/Y, scores them
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic               clk,
  input  logic               rst,
  tt_sweep_checker_if.master sweep_if
);

  state_e                 state_q, state_d;
  logic [VEC_W-1:0]       idx_q, idx_d;
  logic [VEC_W-1:0]       abc_q, abc_d;
  logic [VEC_W-1:0]       first_q, first_d;
  logic [NUM_VECTORS-1:0] expx_q, expx_d;
  logic [NUM_VECTORS-1:0] expy_q, expy_d;
  logic [NUM_VECTORS-1:0] resx_q, resx_d;
  logic [NUM_VECTORS-1:0] resy_q, resy_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   tc;
  logic                   mismatch;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q != RUN),
    .en_i   (state_q == RUN),
    .tc_o   (tc)
  );

  assign mismatch = (sweep_if.X != expx_q[idx_q]) || (sweep_if.Y != expy_q[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abc_d   = abc_q;
    first_d = first_q;
    expx_d  = expx_q;
    expy_d  = expy_q;
    resx_d  = resx_q;
    resy_d  = resy_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        abc_d  = '0;
        busy_d = 1'b0;
        if (sweep_if.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          idx_d   = '0;
          err_d   = '0;
          first_d = '0;
          resx_d  = '0;
          resy_d  = '0;
          pass_d  = 1'b0;
          expx_d  = sweep_if.exp_x;
          expy_d  = sweep_if.exp_y;
        end
      end

      RUN: begin
        if (tc) begin
          resx_d[idx_q] = sweep_if.X;
          resy_d[idx_q] = sweep_if.Y;
          if (mismatch) begin
            err_d = err_q + ERR_W'(1);
            if (err_q == '0) begin
              first_d = idx_q;
            end
          end
          if (idx_q == VEC_W'(NUM_VECTORS - 1)) begin
            // Verdict includes the final vector, so it is taken from err_d.
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abc_d   = '0;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + VEC_W'(1);
            abc_d = idx_d;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      abc_q   <= '0;
      first_q <= '0;
      expx_q  <= '0;
      expy_q  <= '0;
      resx_q  <= '0;
      resy_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      first_q <= first_d;
      expx_q  <= expx_d;
      expy_q  <= expy_d;
      resx_q  <= resx_d;
      resy_q  <= resy_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign sweep_if.A             = abc_q[2];
  assign sweep_if.B             = abc_q[1];
  assign sweep_if.C             = abc_q[0];
  assign sweep_if.busy          = busy_q;
  assign sweep_if.done          = done_q;
  assign sweep_if.pass          = pass_q;
  assign sweep_if.err_count     = err_q;
  assign sweep_if.first_err_idx = first_q;
  assign sweep_if.result_x      = resx_q;
  assign sweep_if.result_y      = resy_q;

endmodule

`default_nettype wire
